// File: rtl/mistral_lut_pkg.sv
// Shared definitions for the LUT mask loader and its evaluator.
//   - legal LUT_K range and a clamp helper
//   - mask geometry helpers (bits per mask, bytes per mask, slot index width)
//   - loader FSM state encodings
package mistral_lut_pkg;

  localparam int LUT_K_MIN = 3;
  localparam int LUT_K_MAX = 6;

  // Loader FSM states (plain constants so older tools and dumps stay readable)
  localparam logic [1:0] S_HDR   = 2'd0;  // expecting a header (slot index) byte
  localparam logic [1:0] S_DATA  = 2'd1;  // collecting mask bytes, LSB byte first
  localparam logic [1:0] S_DRAIN = 2'd2;  // discarding bytes of a bad frame up to IN_LAST

  // Out-of-range K is pulled into the supported range so geometry stays sane.
  function automatic int clamp_lut_k(input int k);
    if (k < LUT_K_MIN) return LUT_K_MIN;
    if (k > LUT_K_MAX) return LUT_K_MAX;
    return k;
  endfunction

  function automatic int mask_width(input int k);
    return 1 << k;
  endfunction

  function automatic int mask_bytes(input int k);
    return (1 << k) / 8;
  endfunction

  // Slot index width, never below one bit so a single-slot build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mistral_lut_eval.sv
// Binary mux-tree LUT evaluator.
//   mask : truth table, bit i is the output for input combination i
//   sel  : LUT inputs, sel[0] = A (LSB select), sel[LUT_K-1] = MSB select
//   q    : mask[sel], purely combinational
// Level 0 collapses adjacent mask bit pairs with sel[0]; each further level
// halves the width again, so the root mux is steered by the MSB input.
module mistral_lut_eval #(
  parameter  int LUT_K = 6,
  localparam int MW    = 1 << LUT_K
) (
  input  logic [MW-1:0]    mask,
  input  logic [LUT_K-1:0] sel,
  output logic             q
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < LUT_K; gi++) begin : g_lvl
      localparam int W = MW >> (gi + 1);
      logic [W-1:0] v;
      for (gj = 0; gj < W; gj++) begin : g_node
        if (gi == 0) begin : g_leaf
          assign v[gj] = sel[gi] ? mask[2*gj+1] : mask[2*gj];
        end else begin : g_inner
          assign v[gj] = sel[gi] ? g_lvl[gi-1].v[2*gj+1] : g_lvl[gi-1].v[2*gj];
        end
      end
    end
  endgenerate

  assign q = g_lvl[LUT_K-1].v[0];

endmodule

// File: rtl/mistral_lut_mask_loader.sv
// LUT mask loader: byte-stream writer for a bank of NUM_LUTS K-input masks.
// A frame is one header byte (slot index) followed by MASK_BYTES data bytes,
// LSB byte first, with in_last on the final data byte only. Complete frames
// land in a shadow bank; commit publishes every pending shadow slot to the
// active bank, which the evaluator reads with zero latency.
// Ports:
//   clk, aclr          clock, asynchronous active-low reset
//   in_valid/in_ready  byte handshake (in_ready registered, high after reset)
//   in_data, in_last   byte payload and end-of-frame marker
//   commit             level: copy pending shadow slots to active each edge
//   eval_idx, eval_in  slot and LUT inputs to evaluate
//   eval_q             active[eval_idx][eval_in], 0 for an out-of-range slot
//   pending            shadow slot written but not yet committed
//   done               one-cycle pulse after a frame is written to shadow
//   err                sticky frame error, cleared only by reset
module mistral_lut_mask_loader
  import mistral_lut_pkg::*;
#(
  parameter  int NUM_LUTS = 8,
  parameter  int LUT_K    = 6,
  localparam int IW       = idx_width(NUM_LUTS)
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  input  logic                commit,
  input  logic [IW-1:0]       eval_idx,
  input  logic [LUT_K-1:0]    eval_in,
  output logic                eval_q,
  output logic [NUM_LUTS-1:0] pending,
  output logic                done,
  output logic                err
);

  localparam int KC = clamp_lut_k(LUT_K);
  localparam int MW = mask_width(KC);
  localparam int MB = mask_bytes(KC);
  localparam int CW = (MB > 1) ? $clog2(MB) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(MB - 1);
  localparam logic [8:0]    NL_HDR   = 9'(NUM_LUTS);
  localparam logic [IW:0]   NL_IDX   = (IW + 1)'(NUM_LUTS);

  logic [1:0]          state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [MW-1:0]       asm_reg, asm_next;
  logic                ready_reg;
  logic                done_reg;
  logic                err_reg;
  logic                err_set;
  logic [NUM_LUTS-1:0] pending_reg;
  logic [MW-1:0]       shadow_reg [NUM_LUTS];
  logic [MW-1:0]       active_reg [NUM_LUTS];

  logic                accept;
  logic                hdr_ok;
  logic                cnt_last;
  logic                frame_ok;
  logic [MW-1:0]       mask_full;
  logic [NUM_LUTS-1:0] slot_wr;
  logic [MW-1:0]       eval_mask;

  assign accept   = in_valid && ready_reg;
  assign hdr_ok   = {1'b0, in_data} < NL_HDR;
  assign cnt_last = (cnt_reg == CNT_LAST);
  assign frame_ok = accept && (state_reg == S_DATA) && cnt_last && in_last;

  // Assembled mask including the byte on the bus this cycle, so the final
  // byte can go straight to shadow (or active) on the completing edge.
  always_comb begin
    mask_full = asm_reg;
    mask_full[8*cnt_reg +: 8] = in_data;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    asm_next   = asm_reg;
    err_set    = 1'b0;
    if (accept) begin
      case (state_reg)
        S_HDR: begin
          if (hdr_ok && !in_last) begin
            state_next = S_DATA;
            idx_next   = in_data[IW-1:0];
            cnt_next   = '0;
          end else begin
            err_set = 1'b1;
            if (!in_last) state_next = S_DRAIN;
          end
        end
        S_DATA: begin
          asm_next = mask_full;
          if (cnt_last) begin
            // Counter holds at the last byte; only the exit path differs.
            if (in_last) begin
              state_next = S_HDR;
            end else begin
              err_set    = 1'b1;
              state_next = S_DRAIN;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
            if (in_last) begin
              err_set    = 1'b1;
              state_next = S_HDR;
            end
          end
        end
        S_DRAIN: begin
          if (in_last) state_next = S_HDR;
        end
        default: state_next = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_reg <= S_HDR;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      asm_reg   <= '0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      asm_reg   <= asm_next;
      ready_reg <= 1'b1;
      done_reg  <= frame_ok;
      err_reg   <= err_reg | err_set;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LUTS; gi++) begin : g_slot
      assign slot_wr[gi] = frame_ok && (idx_reg == IW'(gi));
    end
  endgenerate

  // A frame completing on a commit edge bypasses shadow->active and goes
  // straight to active, so it never shows up as pending.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < NUM_LUTS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
      pending_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_LUTS; i++) begin
        if (slot_wr[i]) shadow_reg[i] <= mask_full;
        if (commit) begin
          if (slot_wr[i])          active_reg[i] <= mask_full;
          else if (pending_reg[i]) active_reg[i] <= shadow_reg[i];
        end
      end
      pending_reg <= commit ? '0 : (pending_reg | slot_wr);
    end
  end

  always_comb begin
    eval_mask = '0;
    if ({1'b0, eval_idx} < NL_IDX) eval_mask = active_reg[eval_idx];
  end

  mistral_lut_eval #(
    .LUT_K (KC)
  ) u_eval (
    .mask (eval_mask),
    .sel  (eval_in[KC-1:0]),
    .q    (eval_q)
  );

  assign in_ready = ready_reg;
  assign pending  = pending_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_mistral_lut_mask_loader.sv
// Bench for mistral_lut_mask_loader.
//   Instance a: NUM_LUTS=8, LUT_K=6, directed frame scenarios.
//   Instance b: NUM_LUTS=6, LUT_K=3, randomized byte stream with valid gaps,
//   checked against a frame-level reference model (a frame is every byte up
//   to and including in_last; it is good iff it is header + one mask and the
//   header names an existing slot).
module tb_mistral_lut_mask_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aclr;
  int   checks = 0;
  int   errors = 0;

  // ---- instance a: K=6, 8 slots ----
  logic       a_valid, a_ready, a_last, a_commit, a_q, a_done, a_err;
  logic [7:0] a_data;
  logic [2:0] a_idx;
  logic [5:0] a_in;
  logic [7:0] a_pend;

  mistral_lut_mask_loader #(.NUM_LUTS(8), .LUT_K(6)) dut_a (
    .clk(clk), .aclr(aclr), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_last(a_last), .commit(a_commit),
    .eval_idx(a_idx), .eval_in(a_in), .eval_q(a_q),
    .pending(a_pend), .done(a_done), .err(a_err)
  );

  // ---- instance b: K=3, 6 slots (slot indices 6,7 are out of range) ----
  logic       b_valid, b_ready, b_last, b_commit, b_q, b_done, b_err;
  logic [7:0] b_data;
  logic [2:0] b_idx;
  logic [2:0] b_in;
  logic [5:0] b_pend;

  mistral_lut_mask_loader #(.NUM_LUTS(6), .LUT_K(3)) dut_b (
    .clk(clk), .aclr(aclr), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_last(b_last), .commit(b_commit),
    .eval_idx(b_idx), .eval_in(b_in), .eval_q(b_q),
    .pending(b_pend), .done(b_done), .err(b_err)
  );

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One accepted byte on instance a; returns #1 after the accepting edge.
  task automatic a_byte(input logic [7:0] b, input logic lst, input logic cmt);
    int t;
    @(negedge clk);
    a_valid = 1'b1; a_data = b; a_last = lst; a_commit = cmt;
    t = 0;
    while (!a_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    chk_val("a_ready_wait", a_ready, 1'b1);
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0; a_commit = 1'b0;
  endtask

  // Header then ndata mask bytes; in_last on data byte last_at (0 = header).
  task automatic a_frame(input logic [7:0] hdr, input logic [63:0] mask,
                         input int ndata, input int last_at, input logic cmt);
    $display("frame hdr=%02h mask=%016h ndata=%0d last_at=%0d commit=%0b",
             hdr, mask, ndata, last_at, cmt);
    a_byte(hdr, last_at == 0, 1'b0);
    for (int k = 1; k <= ndata; k++)
      a_byte(mask[8*((k-1)%8) +: 8], k == last_at, cmt && (k == last_at));
  endtask

  task automatic a_commit_pulse();
    @(negedge clk);
    a_commit = 1'b1;
    @(posedge clk);
    #1;
    a_commit = 1'b0;
  endtask

  // Rebuild a whole active mask by sweeping every LUT input combination.
  task automatic a_read_mask(input logic [2:0] idx, output logic [63:0] m);
    a_idx = idx;
    for (int k = 0; k < 64; k++) begin
      a_in = 6'(k);
      #1;
      m[k] = a_q;
    end
  endtask

  // ---- reference model state for instance b ----
  logic [7:0] m_sh [6];
  logic [7:0] m_ac [6];
  logic [5:0] m_pend;
  logic       m_err;
  logic       m_done;
  logic [8:0] txq [$];   // {last, data} bytes waiting to be offered
  logic [7:0] fq  [$];   // bytes of the frame currently being received

  task automatic gen_frame();
    int kind, ndata;
    logic [7:0] hdr;
    kind = $urandom_range(0, 9);
    if (kind <= 5)      hdr = 8'($urandom_range(0, 5));
    else if (kind == 6) hdr = 8'($urandom_range(6, 255));
    else                hdr = 8'($urandom_range(0, 7));
    if (kind == 6)      ndata = $urandom_range(0, 2);
    else if (kind == 7) ndata = 0;
    else if (kind == 8) ndata = $urandom_range(2, 3);
    else                ndata = 1;
    txq.push_back({ndata == 0, hdr});
    for (int k = 1; k <= ndata; k++)
      txq.push_back({k == ndata, 8'($urandom_range(0, 255))});
  endtask

  logic [63:0] rd;
  logic [63:0] m1b, m2, m6, m7;
  logic [8:0]  cur;
  logic        exp_q;

  initial begin
    aclr = 1'b0;
    a_valid = 0; a_data = 0; a_last = 0; a_commit = 0; a_idx = 0; a_in = 0;
    b_valid = 0; b_data = 0; b_last = 0; b_commit = 0; b_idx = 0; b_in = 0;
    m1b = {$urandom, $urandom}; m2 = {$urandom, $urandom};
    m6  = {$urandom, $urandom}; m7 = {$urandom, $urandom};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_a_ready", a_ready, 1'b0);
    chk_val("rst_a_pend",  a_pend,  8'h00);
    chk_val("rst_a_done",  a_done,  1'b0);
    chk_val("rst_a_err",   a_err,   1'b0);
    chk_val("rst_a_q",     a_q,     1'b0);
    chk_val("rst_b_ready", b_ready, 1'b0);
    chk_val("rst_b_pend",  b_pend,  6'h00);
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    #1;
    chk_val("a_ready_after_rst", a_ready, 1'b1);

    // 1: basic frame to slot 3, then commit
    a_frame(8'h03, 64'h0BAD_F00D_DEAD_BEEF, 8, 8, 1'b0);
    chk_val("t1_done", a_done, 1'b1);
    chk_val("t1_pend", a_pend, 8'h08);
    a_read_mask(3'd3, rd);
    chk_val("t1_active_before_commit", rd, 64'h0);
    a_commit_pulse();
    chk_val("t1_pend_after_commit", a_pend, 8'h00);
    chk_val("t1_done_low", a_done, 1'b0);
    chk_val("t1_err", a_err, 1'b0);
    a_read_mask(3'd3, rd);
    chk_val("t1_active3", rd, 64'h0BAD_F00D_DEAD_BEEF);
    a_idx = 3; a_in = 0; #1;
    chk_val("t1_q_in0", a_q, 1'b1);
    a_in = 4; #1;
    chk_val("t1_q_in4", a_q, 1'b0);

    // 2: out-of-range header drains the frame and sets err
    a_frame(8'h09, 64'hFFFF_FFFF_FFFF_FFFF, 8, 8, 1'b0);
    chk_val("t2_err", a_err, 1'b1);
    chk_val("t2_pend", a_pend, 8'h00);
    chk_val("t2_done", a_done, 1'b0);
    a_frame(8'h06, m6, 8, 8, 1'b0);
    chk_val("t2_next_done", a_done, 1'b1);
    chk_val("t2_next_pend", a_pend, 8'h40);
    a_commit_pulse();
    a_read_mask(3'd6, rd);
    chk_val("t2_active6", rd, m6);

    // 3: early in_last discards the partial mask
    a_frame(8'h01, 64'h1122_3344_5566_7788, 5, 5, 1'b0);
    chk_val("t3_pend", a_pend, 8'h00);
    chk_val("t3_done", a_done, 1'b0);
    a_commit_pulse();
    a_read_mask(3'd1, rd);
    chk_val("t3_active1_zero", rd, 64'h0);
    a_frame(8'h01, m1b, 8, 8, 1'b0);
    chk_val("t3_next_is_header", a_pend, 8'h02);

    // 4: commit on the completing edge; also publishes pending slot 1
    a_frame(8'h02, m2, 8, 8, 1'b1);
    chk_val("t4_done", a_done, 1'b1);
    chk_val("t4_pend", a_pend, 8'h00);
    a_read_mask(3'd2, rd);
    chk_val("t4_active2", rd, m2);
    a_read_mask(3'd1, rd);
    chk_val("t4_active1", rd, m1b);

    // 5: rewrite before commit, last frame wins; then reset mid-frame
    a_frame(8'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8, 8, 1'b0);
    a_frame(8'h05, 64'h8000_0000_0000_0000, 8, 8, 1'b0);
    chk_val("t5_pend", a_pend, 8'h20);
    a_commit_pulse();
    a_idx = 5; a_in = 6'h3F; #1;
    chk_val("t5_q_3f", a_q, 1'b1);
    a_in = 6'h00; #1;
    chk_val("t5_q_00", a_q, 1'b0);
    a_read_mask(3'd5, rd);
    chk_val("t5_active5", rd, 64'h8000_0000_0000_0000);
    a_byte(8'h05, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) a_byte(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    aclr = 1'b0;
    #1;
    chk_val("t5_rst_ready", a_ready, 1'b0);
    chk_val("t5_rst_pend",  a_pend,  8'h00);
    chk_val("t5_rst_err",   a_err,   1'b0);
    a_read_mask(3'd5, rd);
    chk_val("t5_rst_active5", rd, 64'h0);
    a_read_mask(3'd3, rd);
    chk_val("t5_rst_active3", rd, 64'h0);
    chk_val("t5_rst_ready_hold", a_ready, 1'b0);
    @(negedge clk);
    aclr = 1'b1;
    a_frame(8'h07, m7, 8, 8, 1'b0);
    chk_val("t5_hdr_after_rst", a_pend, 8'h80);
    chk_val("t5_done_after_rst", a_done, 1'b1);
    a_commit_pulse();
    a_read_mask(3'd7, rd);
    chk_val("t5_active7", rd, m7);

    // 6: randomized K=3 stream against the frame-level model
    @(negedge clk);
    aclr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end
    m_pend = '0; m_err = 1'b0; m_done = 1'b0;
    txq.delete(); fq.delete();
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      exp_q = (b_idx < 3'd6) ? m_ac[b_idx][b_in] : 1'b0;
      chk_val("r_q", b_q, exp_q);
      chk_val("r_pend", b_pend, m_pend);
      chk_val("r_done", b_done, m_done);
      chk_val("r_ready", b_ready, 1'b1);
      if (fq.size() == 0) chk_val("r_err", b_err, m_err);
      if (txq.size() == 0) gen_frame();
      cur      = txq[0];
      b_valid  = ($urandom_range(0, 3) != 0);
      b_data   = cur[7:0];
      b_last   = cur[8];
      b_commit = ($urandom_range(0, 7) == 0);
      b_idx    = 3'($urandom_range(0, 7));
      b_in     = 3'($urandom_range(0, 7));
      @(posedge clk);
      m_done = 1'b0;
      if (b_valid) begin
        void'(txq.pop_front());
        fq.push_back(cur[7:0]);
        if (cur[8]) begin
          if (fq.size() == 2 && fq[0] < 8'd6) begin
            m_sh[fq[0]]   = fq[1];
            m_pend[fq[0]] = 1'b1;
            m_done        = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          fq.delete();
        end
      end
      if (b_commit) begin
        for (int i = 0; i < 6; i++)
          if (m_pend[i]) m_ac[i] = m_sh[i];
        m_pend = '0;
      end
    end
    @(negedge clk);
    chk_val("r_final_pend", b_pend, m_pend);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
